// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives a 1-cycle synchronous ROM and buffers
// {pc,inst} pairs in a small FIFO for decode. Define FETCH_PERF_EN to add performance counters.
module inst_fetch_unit #(
    parameter logic [31:0] START_ADDR = 32'd0,
    parameter int          FIFO_DEPTH = 4,
    parameter int          ROM_AW     = 6
) (
    input  logic              clk,
    input  logic              reset,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic [31:0]       fetch_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_r;
    logic          inflight_r;
    logic [31:0]   tag_pc_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [31:0]   mem_inst_r [FIFO_DEPTH];
    logic [31:0]   mem_pc_r   [FIFO_DEPTH];

    logic [CW-1:0] occ_s;
    logic          not_empty_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;

    // Credit-based issue, FIFO handshake and head presentation (zero when empty).
    always_comb begin
        occ_s       = count_r + {{(CW-1){1'b0}}, inflight_r};
        not_empty_s = (count_r != {CW{1'b0}});
        issue_s     = !reset && !redirect && (occ_s < DEPTH_C);
        push_s      = inflight_r && !redirect;
        out_valid   = not_empty_s && !redirect;
        pop_s       = out_valid && out_ready;
        rom_en      = issue_s;
        rom_addr    = fetch_pc_r[ROM_AW+1:2];
        fetch_pc    = fetch_pc_r;
        if (not_empty_s) begin
            out_inst = mem_inst_r[rd_ptr_r];
            out_pc   = mem_pc_r[rd_ptr_r];
        end else begin
            out_inst = 32'd0;
            out_pc   = 32'd0;
        end
    end

    // Fetch PC, in-flight tag and FIFO bookkeeping; redirect outranks every other update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= START_ADDR;
            inflight_r <= 1'b0;
            tag_pc_r   <= 32'd0;
            count_r    <= {CW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
            inflight_r <= 1'b0;
            count_r    <= {CW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                tag_pc_r   <= fetch_pc_r;
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Buffer storage; occupancy tracking above decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_inst_r[wr_ptr_r] <= rom_rdata;
            mem_pc_r[wr_ptr_r]   <= tag_pc_r;
        end
    end

`ifdef FETCH_PERF_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + {31'd0, rom_en};
            perf_flush_cnt <= perf_flush_cnt + {31'd0, redirect};
            perf_stall_cnt <= perf_stall_cnt + {31'd0, out_valid && !out_ready};
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a ROM model plus a program-order reference that
// predicts the PC/instruction stream, with directed scenarios and a randomized run.
module tb_inst_fetch_unit;

    localparam logic [31:0] START = 32'd0;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [31:0] rom_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] fetch_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // sampled outputs/inputs of the current cycle
    logic        s_valid, s_ready, s_rom_en, s_redirect, s_reset;
    logic [31:0] s_pc, s_inst, s_rpc, s_fetch_pc;

    // reference model state
    logic [31:0] exp_pc = START;
    int issued = 0;
    int delivered = 0;
    int t_fetch = 0;
    int t_stall = 0;
    int t_flush = 0;

    inst_fetch_unit #(.START_ADDR(START), .FIFO_DEPTH(DEPTH), .ROM_AW(6)) dut (
        .clk(clk), .reset(reset), .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .fetch_pc(fetch_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h1000_0000 + {26'd0, pc[7:2]};
    endfunction

    // synchronous-read ROM holding 0x1000_0000 + word index
    always @(posedge clk) begin
        if (rom_en) rom_rdata <= 32'h1000_0000 + {26'd0, rom_addr};
    end

    task automatic step();
        @(negedge clk);
        s_valid = out_valid; s_ready = out_ready; s_pc = out_pc; s_inst = out_inst;
        s_rom_en = rom_en; s_redirect = redirect; s_rpc = redirect_pc; s_reset = reset;
        s_fetch_pc = fetch_pc;
        @(posedge clk);
        #1;
    endtask

    // advance the program-order reference by one sampled cycle
    task automatic model_advance();
        if (s_reset) begin
            exp_pc = START; issued = 0; delivered = 0;
            t_fetch = 0; t_stall = 0; t_flush = 0;
        end else begin
            t_fetch += int'(s_rom_en);
            t_stall += int'(s_valid && !s_ready);
            t_flush += int'(s_redirect);
            if (s_redirect) begin
                exp_pc = s_rpc & 32'hFFFF_FFFC; issued = 0; delivered = 0;
            end else begin
                if (s_valid && s_ready) begin
                    exp_pc = exp_pc + 32'd4; delivered++;
                end
                if (s_rom_en) issued++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0;
        step(); model_advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b1;
        step();
        n_cmp++;
        if (s_valid !== 1'b0 || s_rom_en !== 1'b0 || s_pc !== 32'd0 || s_inst !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b rom_en=%b pc=%h inst=%h, need 0/0/0/0",
                     s_valid, s_rom_en, s_pc, s_inst);
        end
        n_cmp++;
        if (s_fetch_pc !== START) begin
            n_bad++; $display("FAIL reset_fetch_pc: got %h need %h", s_fetch_pc, START);
        end
        model_advance();
        reset = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) begin
                n_cmp++;
                if (s_rom_en !== 1'b1) begin
                    n_bad++; $display("FAIL first_rom_en: got %b need 1", s_rom_en);
                end
            end
            n_cmp++;
            if (s_valid !== (i >= 2)) begin
                n_bad++; $display("FAIL stream_valid c%0d: got %b need %b", i, s_valid, (i >= 2));
            end
            if (s_valid) begin
                n_cmp++;
                if (s_pc !== exp_pc || s_inst !== rom_word(exp_pc)) begin
                    n_bad++;
                    $display("FAIL stream_word: pc=%h inst=%h, need pc=%h inst=%h",
                             s_pc, s_inst, exp_pc, rom_word(exp_pc));
                end
            end
            model_advance();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i == 10) out_ready = 1'b1;
            step();
            if (s_valid) begin
                n_cmp++;
                if (s_pc !== exp_pc || s_inst !== rom_word(exp_pc)) begin
                    n_bad++;
                    $display("FAIL bp_word: pc=%h inst=%h, need pc=%h inst=%h",
                             s_pc, s_inst, exp_pc, rom_word(exp_pc));
                end
            end
            model_advance();
            if (i == 9) begin
                n_cmp++;
                if (s_rom_en !== 1'b0 || issued - delivered != DEPTH || s_pc !== 32'd0) begin
                    n_bad++;
                    $display("FAIL bp_full: rom_en=%b held=%0d head=%h, need 0/%0d/0",
                             s_rom_en, issued - delivered, s_pc, DEPTH);
                end
            end
        end
    endtask

    task automatic test_redirect();
        logic [2:0] vseq;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); model_advance(); end
        n_cmp++;
        if (issued - delivered != DEPTH) begin
            n_bad++; $display("FAIL redir_setup: held=%0d need %0d", issued - delivered, DEPTH);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0043; out_ready = 1'b1;
        step();
        n_cmp++;
        if (s_valid !== 1'b0 || s_rom_en !== 1'b0) begin
            n_bad++; $display("FAIL redir_cycle: valid=%b rom_en=%b need 0/0", s_valid, s_rom_en);
        end
        model_advance();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vseq[i] = s_valid;
            model_advance();
        end
        n_cmp++;
        if (vseq !== 3'b100 || s_pc !== 32'h40 || s_inst !== 32'h1000_0010) begin
            n_bad++;
            $display("FAIL redir_target: valid_seq=%b pc=%h inst=%h need 100/40/10000010",
                     vseq, s_pc, s_inst);
        end
    endtask

    task automatic test_back_to_back();
        bit found = 0;
        redirect = 1'b1; redirect_pc = 32'h20;
        step(); model_advance();
        redirect_pc = 32'h80;
        step(); model_advance();
        redirect = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            step();
            if (s_valid) begin
                found = 1;
                n_cmp++;
                if (s_pc !== 32'h80 || s_inst !== rom_word(32'h80)) begin
                    n_bad++; $display("FAIL b2b_target: pc=%h need 00000080", s_pc);
                end
            end
            model_advance();
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL b2b_timeout: out_valid never rose, need within 6 cycles");
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] vseq;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); model_advance(); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || rom_en !== 1'b0 || out_pc !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b rom_en=%b pc=%h need 0/0/0", out_valid, rom_en, out_pc);
        end
        step(); model_advance();
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vseq[i] = s_valid;
            model_advance();
        end
        n_cmp++;
        if (vseq !== 3'b100 || s_pc !== START || s_inst !== rom_word(START)) begin
            n_bad++;
            $display("FAIL reset_restart: valid_seq=%b pc=%h inst=%h need 100/%h", vseq, s_pc, s_inst, START);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            step();
            if (s_redirect) begin
                n_cmp++;
                if (s_valid !== 1'b0 || s_rom_en !== 1'b0) begin
                    n_bad++; $display("FAIL rnd_redir: valid=%b rom_en=%b need 0/0", s_valid, s_rom_en);
                end
            end else if (s_valid) begin
                n_cmp++;
                if (s_pc !== exp_pc || s_inst !== rom_word(exp_pc)) begin
                    n_bad++;
                    $display("FAIL rnd_word: pc=%h inst=%h, need pc=%h inst=%h",
                             s_pc, s_inst, exp_pc, rom_word(exp_pc));
                end
            end
            model_advance();
            n_cmp++;
            if (issued - delivered > DEPTH || issued < delivered) begin
                n_bad++; $display("FAIL rnd_occupancy: held=%0d need 0..%0d", issued - delivered, DEPTH);
            end
        end
        redirect = 1'b0;
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin step(); model_advance(); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); model_advance(); end
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        step(); model_advance();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); model_advance(); end
        n_cmp++;
        if (perf_flush_cnt !== 32'd1 || perf_stall_cnt !== 32'd5) begin
            n_bad++;
            $display("FAIL perf_flush_stall: flush=%0d stall=%0d need 1/5", perf_flush_cnt, perf_stall_cnt);
        end
        n_cmp++;
        if (perf_fetch_cnt !== 32'(t_fetch)) begin
            n_bad++; $display("FAIL perf_fetch: got %0d need %0d", perf_fetch_cnt, t_fetch);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_mid_reset();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
